// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller: op codes,
// FSM state encoding and default datapath sizes.
package mdu_ctrl_pkg;

    localparam int MDU_WIDTH    = 32;
    localparam int MDU_DIV_ITER = 32;

    typedef enum logic [2:0] {
        MDU_NOP = 3'd0,
        MULT    = 3'd1,
        MULTU   = 3'd2,
        DIV     = 3'd3,
        DIVU    = 3'd4,
        MTHI    = 3'd5,
        MTLO    = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Ops that occupy the unit for more than one cycle and hold the pipeline.
    function automatic logic is_long_op(input mdu_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, DIV_ITER cycles.
// quot/rem present the result of the step being taken this cycle, valid when last=1.
module div_core
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH    = MDU_WIDTH,
    parameter int DIV_ITER = MDU_DIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The partial remainder fits in WIDTH+1 bits, so the top bit of diff is the borrow.
    always_comb begin
        shifted = {rem_r, quot_r[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_r};
        rem     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quot    = {quot_r[WIDTH-2:0], ~diff[WIDTH]};
    end

    assign last = busy && (cnt == CNT_W'(DIV_ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            rem_r     <= '0;
            quot_r    <= '0;
            divisor_r <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            rem_r     <= '0;
            quot_r    <= dividend;
            divisor_r <= divisor;
        end else if (busy) begin
            rem_r  <= rem;
            quot_r <= quot;
            if (last) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller: owns HI/LO, sequences MULT/DIV variants,
// performs MTHI/MTLO writes and stalls the pipeline during long operations.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DIV_ITER = MDU_DIV_ITER,
    parameter int WIDTH    = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               stall,
    output logic               done,
    output logic [2*WIDTH-1:0] hilo_out
);

    mdu_state_e state, next_state;
    mdu_op_e    op_e;

    logic [2*WIDTH-1:0] hilo;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_signed;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;

    logic               mul_start, mul_wr;
    logic               div_start, div_wr, div_abort;
    logic               hi_wr, lo_wr;
    logic               div_signed, b_zero;
    logic [WIDTH-1:0]   div_dividend, div_divisor;
    logic [WIDTH-1:0]   div_quot, div_rem;
    logic               div_last;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign op_e       = mdu_op_e'(op);
    assign b_zero     = (b == '0);
    assign div_signed = (op_e == DIV);
    assign hilo_out   = hilo;

    // Signed division runs on magnitudes; the signs are reapplied at commit.
    always_comb begin
        div_dividend = (div_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        div_divisor  = (div_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        quot_fix     = neg_q ? (~div_quot + 1'b1) : div_quot;
        rem_fix      = neg_r ? (~div_rem + 1'b1) : div_rem;
    end

    // Low 2*WIDTH bits of the extended product are correct for both signednesses.
    always_comb begin
        ext_a   = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
        ext_b   = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
        product = ext_a * ext_b;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_e)
                            MULT, MULTU: next_state = ST_MUL;
                            DIV, DIVU:   next_state = b_zero ? ST_DONE : ST_DIV;
                            default:     next_state = ST_IDLE;
                        endcase
                    end
                end
                ST_MUL:  next_state = ST_DONE;
                ST_DIV:  next_state = div_last ? ST_DONE : ST_DIV;
                ST_DONE: next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // In MUL/DIV a flush still holds stall this cycle; it only blocks the commit.
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        mul_start = 1'b0;
        mul_wr    = 1'b0;
        div_start = 1'b0;
        div_wr    = 1'b0;
        div_abort = 1'b0;
        hi_wr     = 1'b0;
        lo_wr     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    stall = is_long_op(op_e);
                    case (op_e)
                        MULT, MULTU: mul_start = 1'b1;
                        DIV, DIVU:   div_start = !b_zero;
                        MTHI:        hi_wr     = 1'b1;
                        MTLO:        lo_wr     = 1'b1;
                        default:     ;
                    endcase
                end
            end
            ST_MUL: begin
                stall  = 1'b1;
                mul_wr = !flush;
            end
            ST_DIV: begin
                stall     = 1'b1;
                div_abort = flush;
                div_wr    = !flush && div_last;
            end
            ST_DONE: done = !flush;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hilo       <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            if (mul_start) begin
                mul_a      <= a;
                mul_b      <= b;
                mul_signed <= (op_e == MULT);
            end
            if (div_start) begin
                neg_q <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= div_signed && a[WIDTH-1];
            end
            if (mul_wr)      hilo                <= product;
            else if (div_wr) hilo                <= {rem_fix, quot_fix};
            if (hi_wr)       hilo[2*WIDTH-1:WIDTH] <= a;
            if (lo_wr)       hilo[WIDTH-1:0]       <= a;
        end
    end

    div_core #(
        .WIDTH    (WIDTH),
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quot     (div_quot),
        .rem      (div_rem),
        .last     (div_last)
    );

endmodule
